// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster generator: raw x/y counters, sync/blank decodes,
// line/frame strobes and a frame counter. Every output is registered.
module vga_timing_gen #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int COORD_W   = 10,
  parameter int FRAME_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ce,
  input  logic               resync,
  output logic               hsync,
  output logic               vsync,
  output logic               activevideo,
  output logic [COORD_W-1:0] x_px,
  output logic [COORD_W-1:0] y_px,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_cnt
);

  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

  logic [COORD_W-1:0] x_d, y_d;
  logic [FRAME_W-1:0] frame_d;
  logic               line_d, frame_strobe_d;
  logic               hsync_d, vsync_d, active_d;
  int                 x_i, y_i;

  // Next raster position; resync wins over ce.
  always_comb begin
    x_d            = x_px;
    y_d            = y_px;
    frame_d        = frame_cnt;
    line_d         = 1'b0;
    frame_strobe_d = 1'b0;
    if (resync) begin
      x_d            = '0;
      y_d            = '0;
      line_d         = 1'b1;
      frame_strobe_d = 1'b1;
    end else if (ce) begin
      if (x_px != H_LAST) begin
        x_d = x_px + 1'b1;
      end else begin
        x_d    = '0;
        line_d = 1'b1;
        if (y_px != V_LAST) begin
          y_d = y_px + 1'b1;
        end else begin
          y_d            = '0;
          frame_d        = frame_cnt + 1'b1;
          frame_strobe_d = 1'b1;
        end
      end
    end
  end

  // Decodes are taken from the next position so syncs line up with x/y.
  always_comb begin
    x_i      = int'(x_d);
    y_i      = int'(y_d);
    active_d = (x_i < H_ACTIVE) && (y_i < V_ACTIVE);
    hsync_d  = ((x_i >= HS_START) && (x_i < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
    vsync_d  = ((y_i >= VS_START) && (y_i < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_px        <= '0;
      y_px        <= '0;
      frame_cnt   <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      activevideo <= 1'b1;
      hsync       <= ~HSYNC_POL;
      vsync       <= ~VSYNC_POL;
    end else begin
      x_px        <= x_d;
      y_px        <= y_d;
      frame_cnt   <= frame_d;
      line_start  <= line_d;
      frame_start <= frame_strobe_d;
      activevideo <= active_d;
      hsync       <= hsync_d;
      vsync       <= vsync_d;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: driver pushes expected outputs per edge, monitor pops and
// compares. Instance a uses default timing, instance b a tiny raster.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n_a = 1'b1, ce_a = 1'b0, rs_a = 1'b0;
  logic       hs_a, vs_a, av_a, ls_a, fs_a;
  logic [9:0] x_a, y_a;
  logic [7:0] fc_a;

  logic       rst_n_b = 1'b1, ce_b = 1'b0, rs_b = 1'b0;
  logic       hs_b, vs_b, av_b, ls_b, fs_b;
  logic [3:0] x_b, y_b;
  logic [1:0] fc_b;

  vga_timing_gen u_a (
    .clk(clk), .rst_n(rst_n_a), .ce(ce_a), .resync(rs_a),
    .hsync(hs_a), .vsync(vs_a), .activevideo(av_a),
    .x_px(x_a), .y_px(y_a), .line_start(ls_a), .frame_start(fs_a),
    .frame_cnt(fc_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .COORD_W(4), .FRAME_W(2)
  ) u_b (
    .clk(clk), .rst_n(rst_n_b), .ce(ce_b), .resync(rs_b),
    .hsync(hs_b), .vsync(vs_b), .activevideo(av_b),
    .x_px(x_b), .y_px(y_b), .line_start(ls_b), .frame_start(fs_b),
    .frame_cnt(fc_b)
  );

  localparam int F_X = 0, F_Y = 1, F_HS = 2, F_VS = 3, F_AV = 4, F_LS = 5, F_FS = 6, F_FC = 7;

  int p_ha[2]  = '{640, 4};
  int p_hfp[2] = '{16, 1};
  int p_hsw[2] = '{96, 2};
  int p_hbp[2] = '{48, 1};
  int p_va[2]  = '{480, 3};
  int p_vfp[2] = '{10, 1};
  int p_vsw[2] = '{2, 1};
  int p_vbp[2] = '{33, 1};
  int p_hpl[2] = '{0, 1};
  int p_vpl[2] = '{0, 1};
  int p_fw[2]  = '{8, 2};

  int mx[2], my[2], mf[2], mls[2], mfs[2];

  typedef struct {
    int    dut;
    int    fld;
    int    val;
    string name;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;

  task automatic push(input int d, input int f, input int v, input string n);
    exp_t e;
    e.dut = d; e.fld = f; e.val = v; e.name = n;
    sbq.push_back(e);
  endtask

  task automatic push_model(input int d);
    int hs0, vs0, hexp, vexp;
    hs0  = p_ha[d] + p_hfp[d];
    vs0  = p_va[d] + p_vfp[d];
    hexp = (mx[d] >= hs0 && mx[d] < hs0 + p_hsw[d]) ? p_hpl[d] : 1 - p_hpl[d];
    vexp = (my[d] >= vs0 && my[d] < vs0 + p_vsw[d]) ? p_vpl[d] : 1 - p_vpl[d];
    push(d, F_X,  mx[d], "x_px");
    push(d, F_Y,  my[d], "y_px");
    push(d, F_HS, hexp, "hsync");
    push(d, F_VS, vexp, "vsync");
    push(d, F_AV, (mx[d] < p_ha[d] && my[d] < p_va[d]) ? 1 : 0, "activevideo");
    push(d, F_LS, mls[d], "line_start");
    push(d, F_FS, mfs[d], "frame_start");
    push(d, F_FC, mf[d], "frame_cnt");
  endtask

  task automatic step(input int d, input logic ce, input logic rs);
    int ht, vt;
    @(negedge clk);
    if (d == 0) begin ce_a = ce; rs_a = rs; end
    else        begin ce_b = ce; rs_b = rs; end
    @(posedge clk);
    ht = p_ha[d] + p_hfp[d] + p_hsw[d] + p_hbp[d];
    vt = p_va[d] + p_vfp[d] + p_vsw[d] + p_vbp[d];
    mls[d] = 0;
    mfs[d] = 0;
    if (rs) begin
      mx[d] = 0; my[d] = 0; mls[d] = 1; mfs[d] = 1;
    end else if (ce) begin
      mx[d]++;
      if (mx[d] == ht) begin
        mx[d] = 0; mls[d] = 1; my[d]++;
        if (my[d] == vt) begin
          my[d] = 0; mfs[d] = 1;
          mf[d] = (mf[d] + 1) % (1 << p_fw[d]);
        end
      end
    end
    push_model(d);
  endtask

  task automatic do_reset(input int d, input int hold);
    @(negedge clk);
    if (d == 0) begin ce_a = 1'b0; rs_a = 1'b0; end
    else        begin ce_b = 1'b0; rs_b = 1'b0; end
    #2;
    mx[d] = 0; my[d] = 0; mf[d] = 0; mls[d] = 0; mfs[d] = 0;
    push_model(d);
    push(d, F_LS, 0, "rst_no_line_strobe");
    push(d, F_FS, 0, "rst_no_frame_strobe");
    push(d, F_AV, 1, "rst_active");
    if (d == 0) rst_n_a = 1'b0; else rst_n_b = 1'b0;
    repeat (hold) begin
      @(posedge clk);
      push_model(d);
    end
    @(negedge clk);
    if (d == 0) rst_n_a = 1'b1; else rst_n_b = 1'b1;
  endtask

  function automatic logic [31:0] actual(input int d, input int f);
    logic [31:0] r;
    r = 'x;
    if (d == 0) begin
      case (f)
        F_X: r = 32'(x_a);   F_Y: r = 32'(y_a);
        F_HS: r = 32'(hs_a); F_VS: r = 32'(vs_a);
        F_AV: r = 32'(av_a); F_LS: r = 32'(ls_a);
        F_FS: r = 32'(fs_a); F_FC: r = 32'(fc_a);
        default: r = 'x;
      endcase
    end else begin
      case (f)
        F_X: r = 32'(x_b);   F_Y: r = 32'(y_b);
        F_HS: r = 32'(hs_b); F_VS: r = 32'(vs_b);
        F_AV: r = 32'(av_b); F_LS: r = 32'(ls_b);
        F_FS: r = 32'(fs_b); F_FC: r = 32'(fc_b);
        default: r = 'x;
      endcase
    end
    return r;
  endfunction

  // Monitor: drains the scoreboard shortly after each clock edge or reset.
  initial begin
    exp_t        e;
    logic [31:0] act;
    forever begin
      @(posedge clk or negedge rst_n_a or negedge rst_n_b);
      #1;
      while (sbq.size() > 0) begin
        e   = sbq.pop_front();
        act = actual(e.dut, e.fld);
        checks++;
        if (act !== e.val) begin
          errors++;
          $display("FAIL %s dut%0d actual %0d expected %0d at t=%0t",
                   e.name, e.dut, act, e.val, $time);
        end
      end
    end
  end

  initial begin
    int k, fc_saved;

    // ---- instance a: default 640x480 timing ----
    do_reset(0, 2);
    step(0, 1'b0, 1'b0);
    step(0, 1'b0, 1'b0);
    for (int i = 0; i < 1700; i++) begin
      step(0, 1'b1, 1'b0);
      if (my[0] == 0 && mx[0] == 655) push(0, F_HS, 1, "hs_before_656");
      if (my[0] == 0 && mx[0] == 656) push(0, F_HS, 0, "hs_fall_656");
      if (my[0] == 0 && mx[0] == 751) push(0, F_HS, 0, "hs_last_low_751");
      if (my[0] == 0 && mx[0] == 752) push(0, F_HS, 1, "hs_rise_752");
      if (my[0] == 0 && mx[0] == 640) push(0, F_AV, 0, "av_off_640");
      if (my[0] == 1 && mx[0] == 0)   push(0, F_LS, 1, "line_start_y1");
      if (my[0] == 1 && mx[0] == 1)   push(0, F_LS, 0, "line_start_one_cycle");
    end

    for (int i = 0; i < 3300; i++) step(0, (i % 2) == 0, 1'b0);

    k = 0;
    while (mx[0] != 300 && k < 2000) begin
      step(0, 1'b1, 1'b0);
      k++;
    end
    fc_saved = mf[0];
    step(0, 1'b1, 1'b1);
    push(0, F_X, 0, "resync_x");
    push(0, F_Y, 0, "resync_y");
    push(0, F_LS, 1, "resync_line_start");
    push(0, F_FS, 1, "resync_frame_start");
    push(0, F_FC, fc_saved, "resync_fc_kept");
    step(0, 1'b0, 1'b1);
    push(0, F_FS, 1, "resync_repeat_strobe");
    step(0, 1'b1, 1'b0);
    push(0, F_LS, 0, "resync_strobe_drop");

    k = 0;
    while (mx[0] != 500 && k < 2000) begin
      step(0, 1'b1, 1'b0);
      k++;
    end
    push(0, F_X, 500, "pre_reset_x500");
    do_reset(0, 1);
    step(0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(0, 1'b1, 1'b0);

    // ---- instance b: 8x6 raster, positive syncs, 2-bit frame counter ----
    do_reset(1, 1);
    push(1, F_HS, 0, "b_rst_hsync_pol1");
    push(1, F_VS, 0, "b_rst_vsync_pol1");
    for (k = 1; k <= 202; k++) begin
      step(1, 1'b1, 1'b0);
      if (mx[1] == 5 || mx[1] == 6) push(1, F_HS, 1, "b_hsync_on");
      if (mx[1] == 4 || mx[1] == 7) push(1, F_HS, 0, "b_hsync_off");
      if (my[1] == 4) push(1, F_VS, 1, "b_vsync_on");
      if (my[1] == 3 || my[1] == 5) push(1, F_VS, 0, "b_vsync_off");
      push(1, F_AV, (mx[1] < 4 && my[1] < 3) ? 1 : 0, "b_active_window");
      if (k % 48 == 0) push(1, F_FS, 1, "b_frame_48");
      if (k == 48)  push(1, F_FC, 1, "b_fc_after_first");
      if (k == 144) push(1, F_FC, 3, "b_fc_three");
      if (k == 192) push(1, F_FC, 0, "b_fc_wrap");
    end
    for (int i = 0; i < 4; i++) step(1, 1'b0, 1'b0);
    fc_saved = mf[1];
    step(1, 1'b0, 1'b1);
    push(1, F_FC, fc_saved, "b_resync_fc_kept");
    push(1, F_FS, 1, "b_resync_no_ce");
    step(1, 1'b1, 1'b1);
    for (int i = 0; i < 30; i++) step(1, (i % 2) == 1, 1'b0);

    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain leftover %0d expected 0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
